pc_seq: RTL and testbench
=========================

Name: pc_seq

Overview:
- Parametrised next-generation program counter sequencer for the MIPS core, replacing the fixed 32-bit PC register.
- Keeps the word-addressed PC update modes: normal, branch, jump.
- Adds stall hold, an exception vector with EPC and ERET return, and a small circular return-address stack (RAS) for call/return.
- Sits between decode/ALU control and instruction fetch; current_pc drives the instruction memory address.

Parameters:
- ADDR_W, 32, PC / address width in bits (word address; low byte bits are not carried).
- RESET_PC, 0, PC value loaded on reset.
- EXC_VECTOR, 32'h00000040, PC loaded on an accepted exception.
- RAS_DEPTH, 4, number of return-address stack entries (power of two, >=2).

Ports:
- clk  input  1  system clock; all state updates on negedge clk.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hold PC and RAS this cycle.
- pc_inc_type  input  2  00 normal, 01 branch, 10 jump, 11 unused (treated as normal).
- alu_branch_result  input  1  1 = branch/jump taken.
- abs_addr  input  ADDR_W  absolute jump target.
- branch_addr  input  ADDR_W  signed word offset for branch.
- push_ret  input  1  call: push return address pc+1.
- pop_ret  input  1  return: next PC from RAS top.
- exc_req  input  1  exception request.
- eret  input  1  return from exception.
- current_pc  output  ADDR_W  current PC.
- epc  output  ADDR_W  saved exception PC.
- in_exc  output  1  exception handler active.
- ras_count  output  $clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_underflow  output  1  one-cycle pulse: pop attempted on an empty RAS.

Behaviour:
- Reset (async, rst=1, immediate):
  - current_pc=RESET_PC, epc=0, in_exc=0.
  - ras_count=0, RAS pointer=0, ras_underflow=0.
  - RAS entry contents are don't-care.
- Arithmetic (all truncated to ADDR_W, wrap-around modulo 2^ADDR_W):
  - normal_pc = pc+1.
  - branched_pc = pc+1+$signed(branch_addr).
- Per negedge clk, priority highest first:
  1. exc_req && !in_exc:
     - epc<=pc, pc<=EXC_VECTOR, in_exc<=1.
     - RAS untouched; overrides stall.
  2. eret && in_exc:
     - pc<=epc, in_exc<=0; overrides stall.
     - eret with in_exc=0 is ignored (fall through to lower priorities).
  3. stall:
     - pc, RAS, epc hold; push_ret/pop_ret ignored.
  4. pop_ret:
     - ras_count>0: pc<=RAS top, ras_count decrements.
     - ras_count==0: pc<=normal_pc, ras_underflow=1 for that cycle.
  5. pc_inc_type:
     - 00 or 11: pc<=normal_pc.
     - 01: pc<= alu_branch_result ? branched_pc : normal_pc.
     - 10: pc<= alu_branch_result ? abs_addr : normal_pc.
- exc_req while in_exc=1: ignored (no nesting); the cycle proceeds per lower priorities.
- push_ret: acts only when the cycle resolves at priority 4 or 5 (not exception, eret or stall).
  - Pushes the pre-update pc+1 (truncated) onto the RAS.
- RAS is circular:
  - Push when ras_count==RAS_DEPTH overwrites the oldest entry; ras_count saturates at RAS_DEPTH (no flag).
- push_ret && pop_ret in the same cycle:
  - pc<=old top (if non-empty), then the top slot is replaced by pc+1; ras_count unchanged.
  - If empty: behaves as underflow pop plus push; ras_count becomes 1.
- ras_underflow is registered and clears on the next negedge.
- Reset mid-operation (including during in_exc or a stall) returns everything to reset values immediately.
- Outputs are registered; current_pc changes only on negedge clk or on rst.

Test Plan:
1. Reset then 3 cycles, pc_inc_type=00 -> current_pc 0,1,2,3; in_exc=0; ras_count=0.
2. pc=10, branch type 01, taken, branch_addr=-3 -> pc=8. Same with not taken -> 11. Jump type 10, taken, abs_addr=0x100 -> 0x100.
3. Stack depth and overflow:
   - pc=5, push_ret with jump to 0x20, then pop_ret -> pc 0x20, then 6; ras_count 1 then 0.
   - With RAS_DEPTH=4, 5 pushes -> ras_count=4; 5 pops return the 4 newest return addresses, then the 5th pop pulses ras_underflow with pc=pc+1.
4. Exception and return:
   - pc=0x30, stall=1 and exc_req=1 -> pc=0x40, epc=0x30, in_exc=1.
   - exc_req again -> ignored, pc=0x41.
   - eret -> pc=0x30, in_exc=0.
5. Stall hold and async reset:
   - stall=1 for 3 cycles with push_ret=1 and type 10 taken -> pc and ras_count unchanged.
   - Assert rst between clock edges -> current_pc=RESET_PC immediately.
6. Wrap and combined push/pop:
   - ADDR_W=8, pc=0xFF, normal -> pc=0x00.
   - ras_count=2, push_ret and pop_ret together -> pc=old top, ras_count stays 2, new top = old pc+1.

Source files
------------

// File: rtl/pc_seq.sv
// Program counter sequencer: normal/branch/jump update, stall hold,
// single-level exception entry with EPC/ERET, and a circular return-address stack.
// All state advances on the falling clock edge.
module pc_seq #(
    parameter int unsigned          ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC   = '0,
    parameter logic [ADDR_W-1:0]    EXC_VECTOR = ADDR_W'(32'h00000040),
    parameter int unsigned          RAS_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall,
    input  logic [1:0]                    pc_inc_type,
    input  logic                          alu_branch_result,
    input  logic [ADDR_W-1:0]             abs_addr,
    input  logic [ADDR_W-1:0]             branch_addr,
    input  logic                          push_ret,
    input  logic                          pop_ret,
    input  logic                          exc_req,
    input  logic                          eret,
    output logic [ADDR_W-1:0]             current_pc,
    output logic [ADDR_W-1:0]             epc,
    output logic                          in_exc,
    output logic [$clog2(RAS_DEPTH):0]    ras_count,
    output logic                          ras_underflow
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_EXC = 1'b1
    } mode_t;

    mode_t              r_mode, w_mode_nxt;
    logic [ADDR_W-1:0]  r_pc, w_pc_nxt;
    logic [ADDR_W-1:0]  r_epc, w_epc_nxt;
    logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0]   r_count, w_count_nxt;
    logic               r_underflow, w_underflow_nxt;
    logic [ADDR_W-1:0]  r_ras [RAS_DEPTH];

    logic               w_ras_we;
    logic [PTR_W-1:0]   w_ras_waddr;
    logic [ADDR_W-1:0]  w_normal_pc;
    logic [ADDR_W-1:0]  w_branched_pc;
    logic [PTR_W-1:0]   w_top_idx;
    logic [ADDR_W-1:0]  w_top;
    logic               w_empty;
    logic               w_full;

    // Candidate next-PC values and stack status (r_ptr points at the next free slot)
    assign w_normal_pc   = r_pc + ADDR_W'(1);
    assign w_branched_pc = w_normal_pc + branch_addr;
    assign w_top_idx     = r_ptr - PTR_W'(1);
    assign w_top         = r_ras[w_top_idx];
    assign w_empty       = (r_count == CNT_W'(0));
    assign w_full        = (r_count == CNT_W'(RAS_DEPTH));

    // Next-state decode: exception > eret > stall > return-pop > pc_inc_type
    always_comb begin
        w_mode_nxt      = r_mode;
        w_pc_nxt        = r_pc;
        w_epc_nxt       = r_epc;
        w_ptr_nxt       = r_ptr;
        w_count_nxt     = r_count;
        w_underflow_nxt = 1'b0;
        w_ras_we        = 1'b0;
        w_ras_waddr     = r_ptr;

        if (exc_req && (r_mode == ST_RUN)) begin
            w_epc_nxt  = r_pc;
            w_pc_nxt   = EXC_VECTOR;
            w_mode_nxt = ST_EXC;
        end else if (eret && (r_mode == ST_EXC)) begin
            w_pc_nxt   = r_epc;
            w_mode_nxt = ST_RUN;
        end else if (!stall) begin
            if (pop_ret) begin
                if (!w_empty) begin
                    w_pc_nxt = w_top;
                end else begin
                    w_pc_nxt        = w_normal_pc;
                    w_underflow_nxt = 1'b1;
                end
            end else begin
                unique case (pc_inc_type)
                    2'b01:   w_pc_nxt = alu_branch_result ? w_branched_pc : w_normal_pc;
                    2'b10:   w_pc_nxt = alu_branch_result ? abs_addr : w_normal_pc;
                    default: w_pc_nxt = w_normal_pc;
                endcase
            end

            // Push+pop on a non-empty stack replaces the top in place
            if (push_ret && pop_ret && !w_empty) begin
                w_ras_we    = 1'b1;
                w_ras_waddr = w_top_idx;
            end else if (push_ret) begin
                w_ras_we    = 1'b1;
                w_ras_waddr = r_ptr;
                w_ptr_nxt   = r_ptr + PTR_W'(1);
                w_count_nxt = w_full ? r_count : r_count + CNT_W'(1);
            end else if (pop_ret && !w_empty) begin
                w_ptr_nxt   = w_top_idx;
                w_count_nxt = r_count - CNT_W'(1);
            end
        end
    end

    // Control/PC state register, asynchronously reset
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_mode      <= ST_RUN;
            r_pc        <= RESET_PC;
            r_epc       <= '0;
            r_ptr       <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_mode      <= w_mode_nxt;
            r_pc        <= w_pc_nxt;
            r_epc       <= w_epc_nxt;
            r_ptr       <= w_ptr_nxt;
            r_count     <= w_count_nxt;
            r_underflow <= w_underflow_nxt;
        end
    end

    // Return-address storage; contents need no reset since ras_count gates use
    always_ff @(negedge clk) begin
        if (w_ras_we) begin
            r_ras[w_ras_waddr] <= w_normal_pc;
        end
    end

    assign current_pc    = r_pc;
    assign epc           = r_epc;
    assign in_exc        = (r_mode == ST_EXC);
    assign ras_count     = r_count;
    assign ras_underflow = r_underflow;

endmodule

// File: tb/tb_pc_seq.sv
// Scoreboard bench for pc_seq: directed vectors push hand-computed expectations,
// a monitor pops and compares one entry per cycle.
module tb_pc_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic [1:0]  pc_inc_type = 2'b00;
    logic        alu_branch_result = 1'b0;
    logic [31:0] abs_addr = '0;
    logic [31:0] branch_addr = '0;
    logic        push_ret = 1'b0;
    logic        pop_ret = 1'b0;
    logic        exc_req = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] current_pc;
    logic [31:0] epc;
    logic        in_exc;
    logic [2:0]  ras_count;
    logic        ras_underflow;

    pc_seq #(
        .ADDR_W     (32),
        .RESET_PC   (32'h0),
        .EXC_VECTOR (32'h40),
        .RAS_DEPTH  (4)
    ) u_dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .pc_inc_type       (pc_inc_type),
        .alu_branch_result (alu_branch_result),
        .abs_addr          (abs_addr),
        .branch_addr       (branch_addr),
        .push_ret          (push_ret),
        .pop_ret           (pop_ret),
        .exc_req           (exc_req),
        .eret              (eret),
        .current_pc        (current_pc),
        .epc               (epc),
        .in_exc            (in_exc),
        .ras_count         (ras_count),
        .ras_underflow     (ras_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        logic        ie;
        logic [2:0]  cnt;
        logic        uf;
        int          id;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   vec_id = 0;

    // Pending controls for the next cycle; cleared after each tick
    logic        n_rst = 1'b0, n_stall = 1'b0, n_tk = 1'b0;
    logic        n_push = 1'b0, n_pop = 1'b0, n_exc = 1'b0, n_eret = 1'b0;
    logic [1:0]  n_typ = 2'b00;
    logic [31:0] n_abs = '0, n_br = '0;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL vec%0d %s actual=%h expected=%h", id, name, act, exp);
        end
    endtask

    task automatic apply_controls();
        rst               = n_rst;
        stall             = n_stall;
        pc_inc_type       = n_typ;
        alu_branch_result = n_tk;
        abs_addr          = n_abs;
        branch_addr       = n_br;
        push_ret          = n_push;
        pop_ret           = n_pop;
        exc_req           = n_exc;
        eret              = n_eret;
        n_rst = 1'b0; n_stall = 1'b0; n_tk = 1'b0; n_push = 1'b0;
        n_pop = 1'b0; n_exc = 1'b0; n_eret = 1'b0; n_typ = 2'b00;
        n_abs = '0; n_br = '0;
    endtask

    task automatic tick(input logic [31:0] e_pc, input logic [31:0] e_epc,
                        input logic e_ie, input int e_cnt, input logic e_uf);
        @(posedge clk);
        #1;
        apply_controls();
        q.push_back('{e_pc, e_epc, e_ie, 3'(e_cnt), e_uf, vec_id});
        vec_id++;
    endtask

    // Reset pulse that starts and ends between falling edges
    task automatic tick_rst_pulse(input logic [31:0] e_pc);
        @(posedge clk);
        #1;
        apply_controls();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        q.push_back('{e_pc, 32'h0, 1'b0, 3'd0, 1'b0, vec_id});
        vec_id++;
    endtask

    // Monitor: outputs settle on negedge; sample at the following posedge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("current_pc", e.id, current_pc, e.pc);
                chk("epc", e.id, epc, e.epc);
                chk("in_exc", e.id, 32'(in_exc), 32'(e.ie));
                chk("ras_count", e.id, 32'(ras_count), 32'(e.cnt));
                chk("ras_underflow", e.id, 32'(ras_underflow), 32'(e.uf));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        // Reset and sequential counting
        n_rst = 1'b1; tick(32'h0, 32'h0, 0, 0, 0);
        tick(32'h1, 32'h0, 0, 0, 0);
        tick(32'h2, 32'h0, 0, 0, 0);
        tick(32'h3, 32'h0, 0, 0, 0);
        // Branch / jump
        n_typ = 2'b10; n_tk = 1; n_abs = 32'd10;          tick(32'd10, 0, 0, 0, 0);
        n_typ = 2'b01; n_tk = 1; n_br = 32'hFFFF_FFFD;    tick(32'd8, 0, 0, 0, 0);
        n_typ = 2'b10; n_tk = 1; n_abs = 32'd10;          tick(32'd10, 0, 0, 0, 0);
        n_typ = 2'b01; n_tk = 0; n_br = 32'hFFFF_FFFD;    tick(32'd11, 0, 0, 0, 0);
        n_typ = 2'b10; n_tk = 1; n_abs = 32'h100;         tick(32'h100, 0, 0, 0, 0);
        n_typ = 2'b10; n_tk = 0; n_abs = 32'h200;         tick(32'h101, 0, 0, 0, 0);
        n_typ = 2'b11; n_tk = 1; n_abs = 32'h200;         tick(32'h102, 0, 0, 0, 0);
        n_typ = 2'b01; n_tk = 1; n_br = 32'hFFFF_FF00;    tick(32'h3, 0, 0, 0, 0);
        n_typ = 2'b10; n_tk = 1; n_abs = 32'hFFFF_FFFF;   tick(32'hFFFF_FFFF, 0, 0, 0, 0);
        tick(32'h0, 0, 0, 0, 0);
        // Call / return
        n_typ = 2'b10; n_tk = 1; n_abs = 32'd5;           tick(32'd5, 0, 0, 0, 0);
        n_push = 1; n_typ = 2'b10; n_tk = 1; n_abs = 32'h20; tick(32'h20, 0, 0, 1, 0);
        n_pop = 1;                                        tick(32'd6, 0, 0, 0, 0);
        // Overflow: five pushes, four returns, then underflow
        n_push = 1; tick(32'd7, 0, 0, 1, 0);
        n_push = 1; tick(32'd8, 0, 0, 2, 0);
        n_push = 1; tick(32'd9, 0, 0, 3, 0);
        n_push = 1; tick(32'd10, 0, 0, 4, 0);
        n_push = 1; tick(32'd11, 0, 0, 4, 0);
        n_pop = 1;  tick(32'd11, 0, 0, 3, 0);
        n_pop = 1;  tick(32'd10, 0, 0, 2, 0);
        n_pop = 1;  tick(32'd9, 0, 0, 1, 0);
        n_pop = 1;  tick(32'd8, 0, 0, 0, 0);
        n_pop = 1;  tick(32'd9, 0, 0, 0, 1);
        tick(32'd10, 0, 0, 0, 0);
        // Exception entry/return
        n_typ = 2'b10; n_tk = 1; n_abs = 32'h30;          tick(32'h30, 0, 0, 0, 0);
        n_stall = 1; n_exc = 1;                           tick(32'h40, 32'h30, 1, 0, 0);
        n_exc = 1;                                        tick(32'h41, 32'h30, 1, 0, 0);
        n_eret = 1;                                       tick(32'h30, 32'h30, 0, 0, 0);
        n_eret = 1;                                       tick(32'h31, 32'h30, 0, 0, 0);
        n_exc = 1; n_push = 1;                            tick(32'h40, 32'h31, 1, 0, 0);
        n_eret = 1; n_stall = 1;                          tick(32'h31, 32'h31, 0, 0, 0);
        // Stall holds PC and stack
        n_push = 1; n_typ = 2'b10; n_tk = 1; n_abs = 32'h50; tick(32'h50, 32'h31, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            n_stall = 1; n_push = 1; n_typ = 2'b10; n_tk = 1; n_abs = 32'h99;
            tick(32'h50, 32'h31, 0, 1, 0);
        end
        n_pop = 1;                                        tick(32'h32, 32'h31, 0, 0, 0);
        n_push = 1;                                       tick(32'h33, 32'h31, 0, 1, 0);
        n_exc = 1;                                        tick(32'h40, 32'h33, 1, 1, 0);
        // Asynchronous reset while in the handler
        tick_rst_pulse(32'h1);
        // Combined push/pop
        n_push = 1; n_typ = 2'b10; n_tk = 1; n_abs = 32'h60; tick(32'h60, 0, 0, 1, 0);
        n_push = 1; n_typ = 2'b10; n_tk = 1; n_abs = 32'h70; tick(32'h70, 0, 0, 2, 0);
        n_push = 1; n_pop = 1;                            tick(32'h61, 0, 0, 2, 0);
        n_pop = 1;                                        tick(32'h71, 0, 0, 1, 0);
        n_pop = 1;                                        tick(32'h2, 0, 0, 0, 0);
        n_push = 1; n_pop = 1;                            tick(32'h3, 0, 0, 1, 1);
        n_pop = 1;                                        tick(32'h3, 0, 0, 0, 0);
        n_push = 1; n_typ = 2'b10; n_tk = 1; n_abs = 32'h80; tick(32'h80, 0, 0, 1, 0);
        n_pop = 1; n_typ = 2'b10; n_tk = 1; n_abs = 32'h90;  tick(32'h4, 0, 0, 0, 0);
        n_stall = 1; n_pop = 1;                           tick(32'h4, 0, 0, 0, 0);
        // Drain
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain actual=%0d expected=0 pending", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
